// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// Multi-channel programmable clock divider running on the 50 MHz system clock.
// Each channel k produces a 50% duty square wave clk_out[k] whose high and low
// phases each last half[k] clocks. A one-cycle tick[k] strobe accompanies
// every rising edge of clk_out[k]. Half-periods are runtime writable, and any
// one of them can be read back through a registered port.
//
// Optional feature macro: CLKDIV_SYNC_EN
//   defined   : adds input 'sync'; a high sync restarts the phase of every
//               channel (cnt, clk_out, tick cleared; half values kept unless
//               written in the same cycle).
//   undefined : no sync port, channels run free.
//
// Ports
//   clk50M   in   1      system clock, rising edge
//   rst_n    in   1      synchronous active-low reset
//   en       in   NCH    per-channel run enable (0 = hold phase)
//   wr_en    in   1      half-period write strobe
//   wr_ch    in   CH_W   channel addressed by the write (>= NCH ignored)
//   wr_data  in   CNT_W  new half-period (0 stops the channel)
//   rd_ch    in   CH_W   channel addressed by readback (>= NCH reads 0)
//   rd_data  out  CNT_W  registered half-period of rd_ch
//   clk_out  out  NCH    divided square waves, registered
//   tick     out  NCH    registered strobe on each clk_out rising edge
//   sync     in   1      global phase restart (CLKDIV_SYNC_EN only)
// -----------------------------------------------------------------------------
module clk_div_bank #(
    parameter int NCH   = 4,
    parameter int CNT_W = 26,
    parameter int CH_W  = 4,
    parameter logic [NCH*CNT_W-1:0] DEF_HALF =
        {26'd25_000, 26'd25, 26'd1, 26'd25_000_000}
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CH_W-1:0]  rd_ch,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [CNT_W-1:0] rd_data,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    generate
        if (NCH < 1 || NCH > 16 || (2**CH_W) < NCH) begin : g_bad_param
            $error("clk_div_bank: NCH must be 1..16 and fit in CH_W bits");
        end
    endgenerate

    logic [NCH-1:0][CNT_W-1:0] half_q, half_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
    logic [NCH-1:0]            clk_q,  clk_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic [CNT_W-1:0]          rd_q,   rd_d;

    logic [NCH-1:0]            wr_hit;
    logic                      sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Out-of-range wr_ch matches no channel, so such writes fall away here.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_hit[k] = wr_en && (wr_ch == CH_W'(k));
        end
    end

    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (wr_hit[k]) begin
                half_d[k] = wr_data;
            end
            // A write, a sync or a zero half-period all restart the phase;
            // they outrank a terminal count in the same cycle.
            if (wr_hit[k] || sync_hit || (half_q[k] == '0)) begin
                cnt_d[k] = '0;
                clk_d[k] = 1'b0;
            end else if (en[k]) begin
                if (cnt_q[k] == half_q[k] - CNT_W'(1)) begin
                    cnt_d[k]  = '0;
                    clk_d[k]  = ~clk_q[k];
                    tick_d[k] = ~clk_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_ch == CH_W'(k)) begin
                rd_d = half_q[k];
            end
        end
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            half_q <= DEF_HALF;
            cnt_q  <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            rd_q   <= '0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            rd_q   <= rd_d;
        end
    end

    assign rd_data = rd_q;
    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    localparam int NCH   = 4;
    localparam int CNT_W = 26;
    localparam int CH_W  = 4;

    logic             clk50M;
    logic             rst_n;
    logic [NCH-1:0]   en;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_data;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_data;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
`ifdef CLKDIV_SYNC_EN
    logic             sync;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int ecnt       = 0;
    int tk, hi, tk_sum;

    clk_div_bank #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk50M  (clk50M),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .rd_ch   (rd_ch),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync),
`endif
        .rd_data (rd_data),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to edge number 'target' and park on the following negedge.
    task automatic adv_to(input int target);
        while (ecnt < target) begin
            @(posedge clk50M);
            ecnt++;
            @(negedge clk50M);
        end
    endtask

    // Same as adv_to, counting tick and clk_out highs of one channel.
    task automatic run_count(input int target, input int idx, output int tk_o, output int hi_o);
        tk_o = 0;
        hi_o = 0;
        while (ecnt < target) begin
            @(posedge clk50M);
            ecnt++;
            @(negedge clk50M);
            tk_o += int'(tick[idx]);
            hi_o += int'(clk_out[idx]);
        end
    endtask

    task automatic wr(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = d;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 4'b1111;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;
        rd_ch   = '0;
`ifdef CLKDIV_SYNC_EN
        sync    = 1'b0;
`endif
        // reset defaults
        repeat (3) @(posedge clk50M);
        @(negedge clk50M);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        ecnt  = 0;

        adv_to(1);
        chk("e1_clk_out", 32'(clk_out), 32'b0010);
        chk("e1_tick",    32'(tick),    32'b0010);
        chk("e1_rd_ch0",  32'(rd_data), 32'd25_000_000);
        adv_to(2);
        chk("e2_clk_out", 32'(clk_out), 32'b0000);
        chk("e2_tick",    32'(tick),    32'b0000);
        adv_to(24);
        chk("e24_tick",   32'(tick),    32'b0000);
        adv_to(25);
        chk("e25_clk_out", 32'(clk_out), 32'b0110);
        chk("e25_tick",    32'(tick),    32'b0110);
        adv_to(50);
        chk("e50_clk2",   32'(clk_out[2]), 32'd0);
        adv_to(75);
        chk("e75_tick",   32'(tick),    32'b0110);

        // write ch2 = 3 mid-period (clk_out[2] high here)
        adv_to(80);
        chk("e80_clk2_hi", 32'(clk_out[2]), 32'd1);
        wr(2, 3);
        rd_ch = 2;
        adv_to(81);
        wr_en = 1'b0;
        chk("wr3_clk2",    32'(clk_out[2]), 32'd0);
        chk("wr3_rd_old",  32'(rd_data),    32'd25);
        adv_to(82);
        chk("wr3_rd_new",  32'(rd_data),    32'd3);
        adv_to(83);
        chk("wr3_e2_clk2", 32'(clk_out[2]), 32'd0);
        chk("wr3_rd_2cyc", 32'(rd_data),    32'd3);
        adv_to(84);
        chk("wr3_rise_clk2", 32'(clk_out[2]), 32'd1);
        chk("wr3_rise_tick2", 32'(tick[2]),   32'd1);
        adv_to(85);
        chk("wr3_tick2_one", 32'(tick[2]),    32'd0);
        adv_to(87);
        chk("wr3_fall_clk2", 32'(clk_out[2]), 32'd0);
        adv_to(90);
        chk("wr3_rise2_tick2", 32'(tick[2]),  32'd1);

        // collision: restore half=25 then write on the terminal-count edge
        wr(2, 25);
        adv_to(91);
        wr_en = 1'b0;
        chk("wr25_clk2", 32'(clk_out[2]), 32'd0);
        adv_to(115);
        chk("coll_pre_clk2", 32'(clk_out[2]), 32'd0);
        wr(2, 5);
        adv_to(116);
        wr_en = 1'b0;
        chk("coll_tick2", 32'(tick[2]),    32'd0);
        chk("coll_clk2",  32'(clk_out[2]), 32'd0);
        adv_to(120);
        chk("coll_e4_clk2", 32'(clk_out[2]), 32'd0);
        adv_to(121);
        chk("coll_e5_tick2", 32'(tick[2]),    32'd1);
        chk("coll_e5_clk2",  32'(clk_out[2]), 32'd1);

        // hold ch3 for edges 201..300: first rise moves from 25000 to 25100
        run_count(200, 3, tk, hi);
        tk_sum = tk;
        en[3] = 1'b0;
        run_count(300, 3, tk, hi);
        tk_sum += tk;
        en[3] = 1'b1;
        run_count(25099, 3, tk, hi);
        tk_sum += tk;
        chk("hold_no_tick3",  32'(tk_sum),     32'd0);
        chk("hold_pre_clk3",  32'(clk_out[3]), 32'd0);
        adv_to(25100);
        chk("hold_rise_clk3", 32'(clk_out[3]), 32'd1);
        chk("hold_rise_tick3", 32'(tick[3]),   32'd1);

        // stop ch3 by writing half = 0 while high
        wr(3, 0);
        adv_to(25101);
        wr_en = 1'b0;
        chk("stop_clk3", 32'(clk_out[3]), 32'd0);
        run_count(25301, 3, tk, hi);
        chk("stop_ticks3", 32'(tk), 32'd0);
        chk("stop_highs3", 32'(hi), 32'd0);

        // out-of-range write and readback
        wr(5, 7);
        rd_ch = 5;
        adv_to(25302);
        wr_en = 1'b0;
        chk("oor_rd5",  32'(rd_data), 32'd0);
        adv_to(25303);
        chk("oor_rd5b", 32'(rd_data), 32'd0);
        chk("oor_clk1", 32'(clk_out[1]), 32'd1);
        rd_ch = 0;
        adv_to(25304);
        chk("rd_ch0", 32'(rd_data), 32'd25_000_000);
        rd_ch = 1;
        adv_to(25305);
        chk("rd_ch1", 32'(rd_data), 32'd1);
        rd_ch = 2;
        adv_to(25306);
        chk("rd_ch2", 32'(rd_data), 32'd5);
        rd_ch = 3;
        adv_to(25307);
        chk("rd_ch3", 32'(rd_data), 32'd0);

        // reset mid-period restores defaults
        rst_n = 1'b0;
        repeat (2) @(posedge clk50M);
        @(negedge clk50M);
        chk("rst2_clk_out", 32'(clk_out), 32'd0);
        chk("rst2_tick",    32'(tick),    32'd0);
        chk("rst2_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        ecnt  = 0;
        adv_to(1);
        chk("rst2_rd_ch3",  32'(rd_data), 32'd25_000);
        chk("rst2_e1_clk",  32'(clk_out), 32'b0010);

`ifdef CLKDIV_SYNC_EN
        adv_to(37);
        chk("pre_sync_clk2", 32'(clk_out[2]), 32'd1);
        sync = 1'b1;
        adv_to(38);
        sync = 1'b0;
        chk("sync_clk_out", 32'(clk_out), 32'd0);
        chk("sync_tick",    32'(tick),    32'd0);
        adv_to(62);
        chk("sync_pre_clk2", 32'(clk_out[2]), 32'd0);
        adv_to(63);
        chk("sync_tick2", 32'(tick[2]), 32'd1);
        run_count(25037, 3, tk, hi);
        chk("sync_pre_ticks3", 32'(tk), 32'd0);
        adv_to(25038);
        chk("sync_tick3", 32'(tick[3]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
